// File: rtl/dff_bank_pkg.sv
// dff_bank_pkg
// Shared definitions for the register-bank arbiter and its round-robin picker:
//   - arb_state_e : arbiter FSM states (IDLE, GRANT, LOCKED)
//   - clog2       : index-width helper, never returns less than 1 bit
//   - ptr_rst     : reset value of the round-robin pointer (NREQ-1, so that
//                   requester 0 is searched first after reset)
//   - LCNT_RST    : reset value of the lock counter
package dff_bank_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } arb_state_e;

    // Width needed to index 'value' items; at least 1 so one-entry vectors
    // still get a legal declaration.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

    function automatic int ptr_rst(input int nreq);
        return nreq - 1;
    endfunction

    localparam int LCNT_RST = 0;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational rotating-priority search. Returns the first set bit of
// eligible_i, searching from ptr_i+1 upward and wrapping modulo N.
// Ports:
//   eligible_i [N-1:0]  candidate requesters
//   ptr_i      [PW-1:0] index of the last winner (lowest priority)
//   winner_o   [N-1:0]  one-hot winner, zero when eligible_i is empty
module rr_pick
    import dff_bank_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  eligible_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  winner_o
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        idx      = '0;
        // Offset N wraps back to ptr_i itself, so it is searched last.
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr_i) + k) % N);
            if (!found && eligible_i[idx]) begin
                winner_o[idx] = 1'b1;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter
// Round-robin arbiter with bounded lock that owns a bank of clearable
// registers. Requesters raise req with we/addr/wdata; the access executes
// during the cycle gnt is high and is sampled at the edge that ends it.
// Ports:
//   clk      rising-edge clock
//   clear_n  asynchronous active-low reset
//   req      per-requester access request
//   lock     per-requester request to keep ownership after this grant
//   we       per-requester access type (1 = write, 0 = read)
//   addr     requester i drives [i*ADDR_W +: ADDR_W]
//   wdata    requester i drives [i*WIDTH +: WIDTH]
//   gnt      registered grant, one-hot or zero
//   rdata    read data, held until the next read
//   rvalid   one-cycle pulse, rdata updated
//   rid      one-hot grant that produced rdata
//   q        whole bank, register k at [k*WIDTH +: WIDTH]
module dff_bank_arbiter
    import dff_bank_pkg::*;
#(
    parameter int    NREQ     = 4,
    parameter int    WIDTH    = 8,
    parameter int    ADDR_W   = 2,
    parameter int    LOCK_MAX = 4,
    localparam int   DEPTH    = 2 ** ADDR_W
) (
    input  logic                    clk,
    input  logic                    clear_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         lock,
    input  logic [NREQ-1:0]         we,
    input  logic [NREQ*ADDR_W-1:0]  addr,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        rdata,
    output logic                    rvalid,
    output logic [NREQ-1:0]         rid,
    output logic [DEPTH*WIDTH-1:0]  q
);

    localparam int PTR_W  = clog2(NREQ);
    localparam int LCNT_W = clog2(LOCK_MAX);
    localparam logic [PTR_W-1:0]  PTR_RST_V  = PTR_W'(ptr_rst(NREQ));
    localparam logic [LCNT_W-1:0] LCNT_RST_V = LCNT_W'(LCNT_RST);
    // lcnt counts extra grants beyond the first, so the owner holds at most
    // LOCK_MAX consecutive grants.
    localparam logic [LCNT_W-1:0] LCNT_LAST  = LCNT_W'(LOCK_MAX - 1);

    arb_state_e              state_q, state_d;
    logic [NREQ-1:0]         gnt_q, gnt_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [LCNT_W-1:0]       lcnt_q, lcnt_d;

    logic [NREQ-1:0]         eligible;
    logic [NREQ-1:0]         winner;
    logic [PTR_W-1:0]        winner_idx;
    logic                    hold_lock;

    logic                    access;
    logic                    own_we;
    logic [ADDR_W-1:0]       own_addr;
    logic [WIDTH-1:0]        own_wdata;

    logic [DEPTH-1:0][WIDTH-1:0] bank_q;
    logic [WIDTH-1:0]        rdata_q;
    logic                    rvalid_q;
    logic [NREQ-1:0]         rid_q;

    // The owner of the current grant is masked so a lone requester is
    // served every other cycle and others get a look-in after a release.
    assign eligible = req & ~gnt_q;

    rr_pick #(
        .N  (NREQ),
        .PW (PTR_W)
    ) u_pick (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .winner_o   (winner)
    );

    always_comb begin
        winner_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner[i]) begin
                winner_idx = PTR_W'(i);
            end
        end
    end

    // gnt_q is one-hot, so the AND reduces to the owner's req & lock.
    assign hold_lock = (state_q != IDLE) && (|(gnt_q & req & lock)) &&
                       (lcnt_q < LCNT_LAST);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        lcnt_d  = lcnt_q;
        if (hold_lock) begin
            state_d = LOCKED;
            lcnt_d  = lcnt_q + 1'b1;
        end else if (eligible == '0) begin
            state_d = IDLE;
            gnt_d   = '0;
            lcnt_d  = LCNT_RST_V;
        end else begin
            state_d = GRANT;
            gnt_d   = winner;
            ptr_d   = winner_idx;
            lcnt_d  = LCNT_RST_V;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= PTR_RST_V;
            lcnt_q  <= LCNT_RST_V;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            lcnt_q  <= lcnt_d;
        end
    end

    // Mux the owner's request slices.
    always_comb begin
        own_we    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                own_we    = we[i];
                own_addr  = addr[i*ADDR_W +: ADDR_W];
                own_wdata = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    assign access = |gnt_q;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bank
        always_ff @(posedge clk or negedge clear_n) begin
            if (!clear_n) begin
                bank_q[gi] <= '0;
            end else if (access && own_we && (own_addr == ADDR_W'(gi))) begin
                bank_q[gi] <= own_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
        end else begin
            rvalid_q <= access && !own_we;
            if (access && !own_we) begin
                rdata_q <= bank_q[own_addr];
                rid_q   <= gnt_q;
            end
        end
    end

    assign gnt    = gnt_q;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign rid    = rid_q;
    assign q      = bank_q;

endmodule
